// File: rtl/mcu_spi_arbiter.sv
// mcu_spi_arbiter: round-robin ownership of the shared cartridge-to-MCU SPI link with a guard gap.
// Optional idle-grant watchdog is built when MCU_SPI_ARB_TIMEOUT_EN is defined.
module mcu_spi_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               SClk,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [NUM_REQ-1:0] InSPIDo,
    input  logic [NUM_REQ-1:0] InSPIClkRunning,
    input  logic [NUM_REQ-1:0] InSPIClkStretch,
    input  logic [NUM_REQ-1:0] InnMCUSel,
    input  logic               MCUReadyFallingEdge,
    output logic [NUM_REQ-1:0] Grant,
    output logic [NUM_REQ-1:0] GrantReadyFallingEdge,
    output logic               SPIDo,
    output logic               SPIClkRunning,
    output logic               SPIClkStretch,
    output logic               nMCUSel,
    output logic               Busy,
    output logic               TimeoutFlag
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GC_W  = 8;
    localparam int unsigned TO_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [GC_W-1:0]    guard_q, guard_d;
    logic               timeout_flag_q, timeout_flag_d;

    logic               pick_valid_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic [IDX_W-1:0]   cand_c;
    logic               release_c;

`ifdef MCU_SPI_ARB_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               to_hit_c;
`else
    logic               unused_timeout;
    assign unused_timeout = |TO_W'(TIMEOUT_CYCLES);
`endif

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
    always_comb begin
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        cand_c       = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand_c = IDX_W'((int'(ptr_q) + k) % int'(NUM_REQ));
            if (!pick_valid_c && Req[cand_c]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = cand_c;
            end
        end
    end

    // Next-state logic; a watchdog expiry shares the normal release path
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        guard_d        = guard_q;
        timeout_flag_d = timeout_flag_q;
        release_c      = 1'b0;
`ifdef MCU_SPI_ARB_TIMEOUT_EN
        to_cnt_d       = to_cnt_q;
        to_hit_c       = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    state_d = ST_GRANT;
                    grant_d = NUM_REQ'(1) << pick_idx_c;
                    owner_d = pick_idx_c;
                    ptr_d   = (int'(pick_idx_c) == int'(NUM_REQ) - 1) ? '0 : pick_idx_c + IDX_W'(1);
`ifdef MCU_SPI_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            ST_GRANT: begin
                release_c = !Req[owner_q] && InnMCUSel[owner_q];
`ifdef MCU_SPI_ARB_TIMEOUT_EN
                if (SPIClkRunning || MCUReadyFallingEdge) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    to_hit_c       = 1'b1;
                    timeout_flag_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
                release_c = release_c || to_hit_c;
`endif
                if (release_c) begin
                    grant_d = '0;
                    if (GUARD_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GUARD;
                        guard_d = GC_W'(GUARD_CYCLES);
                    end
                end
            end
            ST_GUARD: begin
                if (guard_q <= GC_W'(1)) begin
                    state_d = ST_IDLE;
                    guard_d = '0;
                end else begin
                    guard_d = guard_q - GC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge SClk) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            owner_q        <= '0;
            ptr_q          <= '0;
            guard_q        <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            owner_q        <= owner_d;
            ptr_q          <= ptr_d;
            guard_q        <= guard_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

`ifdef MCU_SPI_ARB_TIMEOUT_EN
    always_ff @(posedge SClk) begin
        if (Reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // Link mux: only the owner's bits reach the SPIMux; idle levels otherwise
    always_comb begin
        SPIDo                 = 1'b1;
        SPIClkRunning         = 1'b0;
        SPIClkStretch         = 1'b0;
        nMCUSel               = 1'b1;
        GrantReadyFallingEdge = '0;
        if (state_q == ST_GRANT) begin
            SPIDo                          = InSPIDo[owner_q];
            SPIClkRunning                  = InSPIClkRunning[owner_q];
            SPIClkStretch                  = InSPIClkStretch[owner_q];
            nMCUSel                        = InnMCUSel[owner_q];
            GrantReadyFallingEdge[owner_q] = MCUReadyFallingEdge;
        end
    end

    assign Grant       = grant_q;
    assign Busy        = (state_q != ST_IDLE);
    assign TimeoutFlag = timeout_flag_q;

    grant_onehot_a: assert property (@(posedge SClk) $onehot0(grant_q));

endmodule

// File: tb/tb_mcu_spi_arbiter.sv
// tb_mcu_spi_arbiter: directed checks of arbitration order, guard gap, hold, strobe routing and reset.
module tb_mcu_spi_arbiter;

    localparam int unsigned NR = 3;

    logic          SClk = 1'b0;
    logic          Reset;
    logic [NR-1:0] Req;
    logic [NR-1:0] InSPIDo;
    logic [NR-1:0] InSPIClkRunning;
    logic [NR-1:0] InSPIClkStretch;
    logic [NR-1:0] InnMCUSel;
    logic          MCUReadyFallingEdge;
    logic [NR-1:0] Grant;
    logic [NR-1:0] GrantReadyFallingEdge;
    logic          SPIDo;
    logic          SPIClkRunning;
    logic          SPIClkStretch;
    logic          nMCUSel;
    logic          Busy;
    logic          TimeoutFlag;

    int n_tests = 0;
    int n_fail  = 0;

    mcu_spi_arbiter #(
        .NUM_REQ        (NR),
        .GUARD_CYCLES   (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .SClk                  (SClk),
        .Reset                 (Reset),
        .Req                   (Req),
        .InSPIDo               (InSPIDo),
        .InSPIClkRunning       (InSPIClkRunning),
        .InSPIClkStretch       (InSPIClkStretch),
        .InnMCUSel             (InnMCUSel),
        .MCUReadyFallingEdge   (MCUReadyFallingEdge),
        .Grant                 (Grant),
        .GrantReadyFallingEdge (GrantReadyFallingEdge),
        .SPIDo                 (SPIDo),
        .SPIClkRunning         (SPIClkRunning),
        .SPIClkStretch         (SPIClkStretch),
        .nMCUSel               (nMCUSel),
        .Busy                  (Busy),
        .TimeoutFlag           (TimeoutFlag)
    );

    always #5 SClk = ~SClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge SClk);
        #1;
    endtask

    task automatic idle_inputs();
        Req                 = '0;
        InSPIDo             = '1;
        InSPIClkRunning     = '0;
        InSPIClkStretch     = '0;
        InnMCUSel           = '1;
        MCUReadyFallingEdge = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    function automatic int idx_of(input logic [NR-1:0] g);
        idx_of = -1;
        for (int i = 0; i < int'(NR); i++) begin
            if (g[i]) idx_of = i;
        end
    endfunction

    // Bounded wait for any grant; returns -1 when none shows up
    task automatic wait_grant(output int idx);
        idx = -1;
        for (int i = 0; i < 20 && idx < 0; i++) begin
            tick();
            if (Grant != '0) idx = idx_of(Grant);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int cnt;
        int bad;

        // Reset state
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        check("rst_grant", 32'(Grant), 32'h0);
        check("rst_nsel", 32'(nMCUSel), 32'h1);
        check("rst_do", 32'(SPIDo), 32'h1);
        check("rst_run", 32'(SPIClkRunning), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_gref", 32'(GrantReadyFallingEdge), 32'h0);
        check("rst_tflag", 32'(TimeoutFlag), 32'h0);

        // Single requester: 1-cycle latency, output mux, guard gap of 5 cycles
        Reset = 1'b0;
        Req   = 3'b001;
        #1;
        check("t1_pre", 32'(Grant), 32'h0);
        tick();
        check("t1_grant", 32'(Grant), 32'h1);
        check("t1_busy", 32'(Busy), 32'h1);
        InnMCUSel       = 3'b110;
        InSPIDo         = 3'b110;
        InSPIClkRunning = 3'b001;
        #1;
        check("t1_nsel", 32'(nMCUSel), 32'h0);
        check("t1_do", 32'(SPIDo), 32'h0);
        check("t1_run", 32'(SPIClkRunning), 32'h1);
        tick();
        InnMCUSel       = 3'b111;
        InSPIDo         = 3'b111;
        InSPIClkRunning = 3'b000;
        Req             = 3'b010;
        #1;
        check("t1_hold", 32'(Grant), 32'h1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (nMCUSel === 1'b1 && Grant === 3'b000) cnt++;
        end
        check("t1_gap", 32'(cnt), 32'd5);
        tick();
        check("t1_next", 32'(Grant), 32'h2);

        // Three held requesters rotate 0,1,2,0,1,2
        do_reset();
        Req = 3'b111;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            wait_grant(g);
            check("t2_owner", 32'(g), 32'(k % 3));
            for (int c = 0; c < 20; c++) begin
                tick();
                if (!$onehot0(Grant)) bad++;
            end
            if (g >= 0) Req[g] = 1'b0;
            tick();
            if (!$onehot0(Grant)) bad++;
            Req = 3'b111;
        end
        check("t2_onehot", 32'(bad), 32'd0);

        // Owner holds while chip select is low; no preemption by others
        do_reset();
        Req = 3'b010;
        tick();
        check("t3_grant", 32'(Grant), 32'h2);
        InnMCUSel = 3'b101;
        Req       = 3'b011;
        tick();
        Req = 3'b001;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Grant === 3'b010) cnt++;
        end
        check("t3_hold", 32'(cnt), 32'd4);
        InnMCUSel = 3'b111;
        #1;
        check("t3_prerel", 32'(Grant), 32'h2);
        tick();
        check("t3_rel", 32'(Grant), 32'h0);
        check("t3_busy_guard", 32'(Busy), 32'h1);
        wait_grant(g);
        check("t3_next", 32'(g), 32'd0);

        // Ready strobe routed to owner 2 only; dropped during guard
        do_reset();
        Req = 3'b100;
        tick();
        check("t4_grant", 32'(Grant), 32'h4);
        InSPIDo         = 3'b011;
        InSPIClkStretch = 3'b100;
        InSPIClkRunning = 3'b011;
        #1;
        check("t4_do", 32'(SPIDo), 32'h0);
        check("t4_stretch", 32'(SPIClkStretch), 32'h1);
        check("t4_run", 32'(SPIClkRunning), 32'h0);
        MCUReadyFallingEdge = 1'b1;
        #1;
        check("t4_gref", 32'(GrantReadyFallingEdge), 32'h4);
        tick();
        MCUReadyFallingEdge = 1'b0;
        #1;
        check("t4_gref_off", 32'(GrantReadyFallingEdge), 32'h0);
        InSPIDo         = 3'b111;
        InSPIClkStretch = 3'b000;
        InSPIClkRunning = 3'b000;
        Req             = 3'b000;
        tick();
        MCUReadyFallingEdge = 1'b1;
        #1;
        check("t4_gref_guard", 32'(GrantReadyFallingEdge), 32'h0);
        check("t4_busy_guard", 32'(Busy), 32'h1);
        tick();
        MCUReadyFallingEdge = 1'b0;

        // Reset mid-transfer idles the link immediately, no guard afterwards
        do_reset();
        Req = 3'b001;
        tick();
        check("t5_grant", 32'(Grant), 32'h1);
        InnMCUSel       = 3'b110;
        InSPIClkRunning = 3'b001;
        #1;
        check("t5_run_on", 32'(SPIClkRunning), 32'h1);
        Reset = 1'b1;
        tick();
        check("t5_nsel", 32'(nMCUSel), 32'h1);
        check("t5_run_off", 32'(SPIClkRunning), 32'h0);
        check("t5_grant_off", 32'(Grant), 32'h0);
        check("t5_busy", 32'(Busy), 32'h0);
        Reset = 1'b0;
        Req   = 3'b010;
        tick();
        check("t5_regrant", 32'(Grant), 32'h2);

        // Idle grant: watchdog release when built, otherwise held indefinitely
        do_reset();
        Req = 3'b001;
        tick();
        check("t6_grant", 32'(Grant), 32'h1);
`ifdef MCU_SPI_ARB_TIMEOUT_EN
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (Grant !== 3'b001) break;
            cnt++;
        end
        check("t6_to_len", 32'(cnt), 32'd100);
        check("t6_flag", 32'(TimeoutFlag), 32'h1);
        Req = 3'b000;
        repeat (10) tick();
        check("t6_flag_sticky", 32'(TimeoutFlag), 32'h1);
        do_reset();
        check("t6_flag_clr", 32'(TimeoutFlag), 32'h0);
`else
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (Grant === 3'b001) cnt++;
        end
        check("t6_held", 32'(cnt), 32'd1000);
        check("t6_flag", 32'(TimeoutFlag), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_spi_arbiter.md
Name: mcu_spi_arbiter

Overview:
- Shares the single cartridge-to-MCU SPI link between several FPGA-side SPI masters (RTC bridge, cart serial/EEPROM bridge, user SPI port).
- Each master requests the link, is granted exclusive ownership for a whole transaction, and releases it. The arbiter then forces a guard gap before the next grant.
- Muxes the per-master SPI control signals into the SPIMux inputs.
- Routes the MCU ready falling-edge strobe only to the current owner.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
GUARD_CYCLES, 4, SClk cycles nMCUSel is held high between transactions (0..255)
TIMEOUT_CYCLES, 65535, idle-grant watchdog limit (used only with MCU_SPI_ARB_TIMEOUT_EN)

Ports:
SClk  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
Req  input  NUM_REQ  per-requester link request, level
InSPIDo  input  NUM_REQ  per-requester next MOSI bit
InSPIClkRunning  input  NUM_REQ  per-requester clock-running
InSPIClkStretch  input  NUM_REQ  per-requester clock-stretch
InnMCUSel  input  NUM_REQ  per-requester chip select, active low
MCUReadyFallingEdge  input  1  one-cycle strobe from MCU ready line
Grant  output  NUM_REQ  one-hot ownership, registered
GrantReadyFallingEdge  output  NUM_REQ  MCUReadyFallingEdge gated to the owner
SPIDo  output  1  to SPIMux InSPIDo
SPIClkRunning  output  1  to SPIMux ClockRunning
SPIClkStretch  output  1  to SPIMux ClockStretch
nMCUSel  output  1  to SPIMux InSPISel
Busy  output  1  state != IDLE
TimeoutFlag  output  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset (synchronous, active-high):
  - State=IDLE, Grant=0, round-robin pointer=0, guard counter=0, TimeoutFlag=0.
  - Outputs idle: nMCUSel=1, SPIDo=1, SPIClkRunning=0, SPIClkStretch=0, Busy=0, GrantReadyFallingEdge=0.
  - Reset mid-transaction: outputs go idle at the reset edge; no guard period is applied.
- IDLE:
  - If any Req is high, pick the first set bit searching from pointer, pointer+1, ... with wrap modulo NUM_REQ.
  - At the next edge: Grant[i]=1, state=GRANT, pointer=i+1 (wraps to 0).
  - Latency from Req sampled high in IDLE to Grant high is 1 cycle.
- GRANT (owner g):
  - Outputs are combinational copies of owner g's In* bits.
  - GrantReadyFallingEdge[g]=MCUReadyFallingEdge; all other bits of GrantReadyFallingEdge are 0.
  - Release condition: Req[g]==0 AND InnMCUSel[g]==1.
  - Dropping Req while InnMCUSel[g]==0 does not release; ownership is held until chip select deasserts.
  - On release: Grant=0 and outputs idle at the same edge; state=GUARD with counter=GUARD_CYCLES. If GUARD_CYCLES==0, state=IDLE instead.
  - Requests from non-owners are ignored during GRANT; no preemption.
- GUARD:
  - Outputs idle, Grant=0.
  - Counter decrements each cycle; at 1, next state=IDLE.
  - nMCUSel is therefore high for exactly GUARD_CYCLES+1 cycles minimum between owners (GUARD cycles plus the IDLE arbitration cycle).
- Simultaneous requests: round-robin from pointer. Two requesters held continuously alternate.
- Same requester re-requesting immediately after release still waits out GUARD and IDLE, and loses to any other pending requester positioned earlier in round-robin order.
- MCUReadyFallingEdge arriving outside GRANT is dropped; it is not queued.
- Grant is always one-hot or zero. An assertion must check this.

Optional Feature:
MCU_SPI_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit counter resets on every GRANT entry and on every cycle where SPIClkRunning or MCUReadyFallingEdge is high; otherwise it increments while in GRANT.
  - On reaching TIMEOUT_CYCLES, ownership is forcibly released (same path as a normal release, into GUARD) and TimeoutFlag is set.
  - TimeoutFlag is cleared only by Reset.
- Undefined: no counter is built, TimeoutFlag is tied 0, and a grant is held indefinitely.

Test Plan:
- Reset then Req=3'b001 -> Grant=3'b001 exactly 1 cycle later; nMCUSel follows InnMCUSel[0]; after Req[0]=0 and InnMCUSel[0]=1, Grant=0 next edge and nMCUSel held high for 5 cycles (GUARD_CYCLES=4) before any new grant.
- Req=3'b111 held constant, each owner releasing after 20 cycles -> grant order 0,1,2,0,1,2; never two Grant bits high.
- Owner 1 drops Req while InnMCUSel[1]=0 -> Grant stays 3'b010 until InnMCUSel[1]=1, then releases at the next edge.
- MCUReadyFallingEdge pulses while owner 2 is granted -> GrantReadyFallingEdge=3'b100 for 1 cycle; a pulse during GUARD -> GrantReadyFallingEdge stays 0.
- Reset asserted mid-transfer with owner 0 and SPIClkRunning=1 -> next edge nMCUSel=1, SPIClkRunning=0, Grant=0; Req[1] afterwards is granted (pointer=0, Req[0] low).
- With MCU_SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: owner idles with no clock activity -> forced release at cycle 100 and TimeoutFlag=1, flag persists until Reset. Without the macro -> Grant held 1000 cycles and TimeoutFlag=0.
